// File: rtl/demux_dispatch_ctrl_pkg.sv
// rtl/demux_dispatch_ctrl_pkg.sv - shared constants and FSM state type for the round-robin dispatcher
package demux_dispatch_pkg;
  localparam int NCH   = 4;
  localparam int SEL_W = 2;
  localparam int CNT_W = 16;

  typedef enum logic {ST_IDLE, ST_HOLD} state_t;
endpackage

// File: rtl/demux_dispatch_ctrl_if.sv
// rtl/demux_dispatch_ctrl_if.sv - source handshake, channel handshakes and demux steering bundle
interface demux_dispatch_if #(parameter int DW = 8);
  import demux_dispatch_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    in_data;
  logic [NCH-1:0]   out_valid;
  logic [NCH-1:0]   out_ready;
  logic [DW-1:0]    out_data;
  logic [SEL_W-1:0] sel;
  logic             busy;

  modport master (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, sel, busy
  );

  modport slave (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, sel, busy
  );
endinterface

// File: rtl/demux_dispatch_ctrl_rr_pick4.sv
// rtl/demux_dispatch_ctrl_rr_pick4.sv - combinational rotating-priority picker over four channels
module rr_pick4
  import demux_dispatch_pkg::*;
(
  input  logic [NCH-1:0]   mask,
  input  logic [SEL_W-1:0] start,
  output logic [SEL_W-1:0] idx,
  output logic             any
);
  logic [2*NCH-1:0] dbl;
  logic [NCH-1:0]   rot;

  always_comb begin
    // rot[i] is the enable of channel start+i (mod 4); lowest i wins
    dbl = {mask, mask} >> start;
    rot = dbl[NCH-1:0];
    idx = start;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (rot[i]) idx = start + SEL_W'(i);
    end
    any = |mask;
  end
endmodule

// File: rtl/demux_dispatch_ctrl.sv
// rtl/demux_dispatch_ctrl.sv - round-robin dispatcher steering a one-entry hold register to four channels
// Optional per-channel transfer counters: DISPATCH_CNT_EN
module demux_dispatch_ctrl
  import demux_dispatch_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH-1:0]   en_mask,
`ifdef DISPATCH_CNT_EN
  input  logic [SEL_W-1:0] cnt_sel,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt_q,
`endif
  demux_dispatch_if.master bus
);
  state_t           state, state_n;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] sel_q;
  logic [DW-1:0]    hold;
  logic [SEL_W-1:0] pick_start;
  logic [SEL_W-1:0] pick_idx;
  logic             pick_any;
  logic             in_ready_c;
  logic             in_fire;
  logic             out_fire;
  logic             load;

  // In HOLD the next choice rotates from the channel just served, not the stale ptr
  assign pick_start = (state == ST_HOLD) ? sel_q + 1'b1 : ptr;

  rr_pick4 u_pick (
    .mask  (en_mask),
    .start (pick_start),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign out_fire   = (state == ST_HOLD) && bus.out_ready[sel_q];
  assign in_ready_c = pick_any && ((state == ST_IDLE) || bus.out_ready[sel_q]);
  assign in_fire    = bus.in_valid && in_ready_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (in_fire) begin
          load    = 1'b1;
          state_n = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_fire) begin
          load    = in_fire;
          state_n = in_fire ? ST_HOLD : ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr   <= '0;
      sel_q <= '0;
      hold  <= '0;
    end else begin
      if (out_fire) ptr <= sel_q + 1'b1;
      if (load) begin
        hold  <= bus.in_data;
        sel_q <= pick_idx;
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = (state == ST_HOLD) ? ({{(NCH-1){1'b0}}, 1'b1} << sel_q) : '0;
  assign bus.out_data  = hold;
  assign bus.sel       = sel_q;
  assign bus.busy      = (state == ST_HOLD);

`ifdef DISPATCH_CNT_EN
  logic [CNT_W-1:0] cnt [NCH];

  // Clear has priority over a same-cycle increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NCH; k++) cnt[k] <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (cnt_clr)                               cnt[k] <= '0;
        else if (out_fire && sel_q == SEL_W'(k))   cnt[k] <= cnt[k] + 1'b1;
      end
    end
  end

  assign cnt_q = cnt[cnt_sel];
`endif
endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// tb/tb_demux_dispatch_ctrl.sv - directed and randomized checks of demux_dispatch_ctrl against a queue-level model
// Counter checks run when DISPATCH_CNT_EN is defined
module tb_demux_dispatch_ctrl;
  import demux_dispatch_pkg::*;

  localparam int DW = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] en_mask;

  demux_dispatch_if #(.DW(DW)) bus ();

`ifdef DISPATCH_CNT_EN
  logic [1:0]  cnt_sel;
  logic        cnt_clr;
  logic [15:0] cnt_q;
`endif

  demux_dispatch_ctrl #(.DW(DW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_mask (en_mask),
`ifdef DISPATCH_CNT_EN
    .cnt_sel (cnt_sel),
    .cnt_clr (cnt_clr),
    .cnt_q   (cnt_q),
`endif
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit quiet = 1'b0;

  // Reference state: is a word held, which channel, what data, where rotation resumes
  bit          m_hold;
  int          m_sel;
  int          m_ptr;
  logic [7:0]  m_data;
  int          m_cnt [4];
  int          n_acc;
  int          n_cyc;
  int          del_ch[$];
  logic [7:0]  del_data[$];
  int          del_cyc[$];

  int         rot_exp [5]  = '{0, 1, 2, 3, 0};
  int         mask_exp [5] = '{1, 3, 1, 3, 1};
  int         mchg_exp [4] = '{0, 1, 2, 3};
  logic [7:0] rot_dat [5]  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

  function automatic int pick(input logic [3:0] m, input int start);
    for (int i = 0; i < 4; i++) begin
      if (m[(start + i) % 4]) return (start + i) % 4;
    end
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic model_reset();
    m_hold = 1'b0;
    m_sel  = 0;
    m_ptr  = 0;
    m_data = 8'h00;
    for (int k = 0; k < 4; k++) m_cnt[k] = 0;
  endtask

  // Called after a falling edge with inputs set; checks outputs, advances the model, moves one cycle
  task automatic cycle();
    bit         rdy, in_t, out_t;
    int         start;
    logic [3:0] ov;
    #1;
    rdy = (en_mask != 4'h0) && (!m_hold || bus.out_ready[m_sel]);
    ov  = m_hold ? (4'b0001 << m_sel) : 4'b0000;
    if (!quiet) begin
      chk("in_ready", 32'(bus.in_ready), 32'(rdy));
      chk("out_valid", 32'(bus.out_valid), 32'(ov));
      chk("sel", 32'(bus.sel), 32'(m_sel));
      chk("out_data", 32'(bus.out_data), 32'(m_data));
      chk("busy", 32'(bus.busy), 32'(m_hold));
`ifdef DISPATCH_CNT_EN
      chk("cnt_q", 32'(cnt_q), 32'(m_cnt[cnt_sel]));
`endif
    end
    in_t  = bus.in_valid && rdy;
    out_t = m_hold && bus.out_ready[m_sel];
`ifdef DISPATCH_CNT_EN
    for (int k = 0; k < 4; k++) begin
      if (cnt_clr)                   m_cnt[k] = 0;
      else if (out_t && m_sel == k)  m_cnt[k] = (m_cnt[k] + 1) % 65536;
    end
`endif
    if (out_t) begin
      m_ptr = (m_sel + 1) % 4;
      del_ch.push_back(m_sel);
      del_data.push_back(m_data);
      del_cyc.push_back(n_cyc);
    end
    if (in_t) begin
      start  = m_hold ? (m_sel + 1) % 4 : m_ptr;
      m_sel  = pick(en_mask, start);
      m_data = bus.in_data;
      m_hold = 1'b1;
      n_acc++;
    end else if (out_t) begin
      m_hold = 1'b0;
    end
    n_cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_log();
    del_ch.delete();
    del_data.delete();
    del_cyc.delete();
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    model_reset();
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    en_mask       = 4'hF;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 4'h0;
    n_acc = 0;
    n_cyc = 0;
`ifdef DISPATCH_CNT_EN
    cnt_sel = 2'd0;
    cnt_clr = 1'b0;
`endif
    model_reset();
    @(negedge clk);
    do_reset();

    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_sel", 32'(bus.sel), 32'h0);
    chk("rst_out_data", 32'(bus.out_data), 32'h0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'h1);

    // Rotation over all four channels at full throughput
    clear_log();
    bus.out_ready = 4'hF;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = rot_dat[i];
      cycle();
    end
    bus.in_valid = 1'b0;
    cycle();
    cycle();
    chk("rot_count", 32'(del_ch.size()), 32'd5);
    if (del_ch.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        chk("rot_ch", 32'(del_ch[i]), 32'(rot_exp[i]));
        chk("rot_data", 32'(del_data[i]), 32'(rot_dat[i]));
      end
      chk("rot_no_bubble", 32'(del_cyc[4] - del_cyc[0]), 32'd4);
    end

    // Masking: only channels 1 and 3 eligible
    clear_log();
    en_mask = 4'b1010;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'($urandom);
      cycle();
    end
    bus.in_valid = 1'b0;
    cycle();
    cycle();
    chk("mask_count", 32'(del_ch.size()), 32'd5);
    if (del_ch.size() == 5) begin
      for (int i = 0; i < 5; i++) chk("mask_ch", 32'(del_ch[i]), 32'(mask_exp[i]));
    end

    en_mask = 4'b0000;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("mask0_in_ready", 32'(bus.in_ready), 32'h0);
    end
    chk("mask0_busy", 32'(bus.busy), 32'h0);
    bus.in_valid = 1'b0;

    // Backpressure on channel 0, then bypass into channel 1
    en_mask = 4'hF;
    do_reset();
    clear_log();
    bus.out_ready = 4'h0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'hA5;
    cycle();
    bus.in_data = 8'h5A;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("bp_in_ready", 32'(bus.in_ready), 32'h0);
      chk("bp_sel", 32'(bus.sel), 32'h0);
      chk("bp_data", 32'(bus.out_data), 32'hA5);
      chk("bp_valid", 32'(bus.out_valid), 32'h1);
    end
    bus.out_ready = 4'b0001;
    #1;
    chk("bp_release_ready", 32'(bus.in_ready), 32'h1);
    cycle();
    chk("bp_next_sel", 32'(bus.sel), 32'h1);
    chk("bp_next_data", 32'(bus.out_data), 32'h5A);
    bus.in_valid  = 1'b0;
    bus.out_ready = 4'hF;
    cycle();
    cycle();
    chk("bp_count", 32'(del_ch.size()), 32'd2);

    // Clearing the enable of the held channel does not cancel its word
    do_reset();
    clear_log();
    en_mask       = 4'hF;
    bus.out_ready = 4'hF;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_data = 8'(8'h30 + i);
      cycle();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 4'h0;
    en_mask       = 4'b1011;
    cycle();
    chk("mchg_held_sel", 32'(bus.sel), 32'h2);
    bus.out_ready = 4'b0100;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h3F;
    cycle();
    bus.in_valid  = 1'b0;
    bus.out_ready = 4'hF;
    cycle();
    cycle();
    chk("mchg_count", 32'(del_ch.size()), 32'd4);
    if (del_ch.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("mchg_ch", 32'(del_ch[i]), 32'(mchg_exp[i]));
    end

    // Reset asserted while channel 2 is held
    do_reset();
    en_mask       = 4'hF;
    bus.out_ready = 4'hF;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_data = 8'(8'h70 + i);
      cycle();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 4'h0;
    cycle();
    chk("rsth_pre_sel", 32'(bus.sel), 32'h2);
    chk("rsth_pre_busy", 32'(bus.busy), 32'h1);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rsth_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rsth_busy", 32'(bus.busy), 32'h0);
    chk("rsth_sel", 32'(bus.sel), 32'h0);
    cycle();
    rst_n = 1'b1;
    #1;
    chk("rsth_in_ready", 32'(bus.in_ready), 32'h1);
    cycle();

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      if (i % 8 == 0) en_mask = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom);
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_data   = 8'($urandom);
      bus.out_ready = 4'($urandom);
`ifdef DISPATCH_CNT_EN
      cnt_sel = 2'($urandom);
      cnt_clr = ($urandom_range(0, 40) == 0);
`endif
      cycle();
    end
    bus.in_valid = 1'b0;
`ifdef DISPATCH_CNT_EN
    cnt_clr = 1'b0;
`endif

`ifdef DISPATCH_CNT_EN
    // 70000 transfers on channel 0 wrap the 16-bit counter to 0x1170
    do_reset();
    en_mask       = 4'b0001;
    bus.out_ready = 4'hF;
    cnt_sel       = 2'd0;
    n_acc         = 0;
    quiet         = 1'b1;
    for (int i = 0; i < 70010 && n_acc < 70000; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(i);
      cycle();
    end
    bus.in_valid = 1'b0;
    cycle();
    quiet = 1'b0;
    cycle();
    chk("cnt_accepted", 32'(n_acc), 32'd70000);
    chk("cnt_wrap", 32'(cnt_q), 32'h1170);

    bus.in_valid = 1'b1;
    cycle();
    bus.in_valid = 1'b0;
    cnt_clr = 1'b1;
    cycle();
    cnt_clr = 1'b0;
    #1;
    chk("cnt_clr", 32'(cnt_q), 32'h0);
    cycle();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
